// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Fetches one instruction at a time from instruction memory. It hands the
// instruction to the decode stage (IDU) and follows control-flow redirects
// from the execute stage.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   redirect_valid    redirect request from EXU (taken branch / jump)
//   redirect_pc       redirect target; bits [1:0] are forced to zero
//   imem_req_valid    fetch request valid (asserted in REQ only)
//   imem_req_addr     fetch address (the current pc)
//   imem_req_ready    memory accepts the request
//   imem_rsp_valid    fetch data valid (only honoured in WAIT)
//   imem_rsp_data     fetched instruction word
//   out_valid         instruction valid toward IDU (asserted in HOLD only)
//   out_instr         held instruction
//   out_pc            pc of the held instruction
//   out_ready         IDU accepts the instruction
//   dbg_state         current FSM state, for debug and checkers
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. The producer keeps valid and payload stable until that edge.
// The consumer may drive ready without looking at valid. Every output is a
// register or is decoded from the state register only, so no input reaches
// an output in the same cycle.
// ----------------------------------------------------------------------------
module ifu #(
    parameter int              XLEN     = 32,
    parameter int              INST_DW  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INST_DW-1:0] imem_rsp_data,
    output logic               out_valid,
    output logic [INST_DW-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    input  logic               out_ready,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               kill_q, kill_d;
    logic [INST_DW-1:0] instr_q, instr_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;

    // Redirect targets are word aligned: the low two bits are dropped.
    logic [XLEN-1:0]    redirect_aligned;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            instr_q  <= '0;
            out_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;

        unique case (state_q)
            S_IDLE: begin
                // Redirects are ignored here; the first fetch is always RESET_PC.
                pc_d    = RESET_PC;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                    // A request accepted in this same cycle targets the old pc.
                    // Its response must be thrown away.
                    if (imem_req_ready) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                    if (imem_rsp_valid) begin
                        // The response belongs to the stale path: drop it and
                        // refetch at once.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d  = imem_rsp_data;
                        out_pc_d = pc_q;
                        state_d  = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect wins over a same-cycle IDU handshake. The held
                // instruction is dropped and pc does not advance past it.
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    state_d = S_REQ;
                end else if (out_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign out_valid      = (state_q == S_HOLD);
    assign out_instr      = instr_q;
    assign out_pc         = out_pc_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu.
// A table of fetch vectors (memory/IDU stall lengths, instruction word and
// expected pc) is replayed through a lockstep driver. It is followed by
// hand-written redirect and reset sequences. Instructions accepted by IDU are
// compared against an expected queue filled when the response is driven.
// ----------------------------------------------------------------------------
module tb_ifu;
    localparam int XLEN    = 32;
    localparam int INST_DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               redirect_valid = 1'b0;
    logic [XLEN-1:0]    redirect_pc = '0;
    logic               imem_req_valid;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_req_ready = 1'b0;
    logic               imem_rsp_valid = 1'b0;
    logic [INST_DW-1:0] imem_rsp_data = '0;
    logic               out_valid;
    logic [INST_DW-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;
    logic               out_ready = 1'b0;
    logic [1:0]         dbg_state;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];   // {pc, instr} expected at each IDU handshake

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every IDU handshake not cancelled by a redirect consumes one entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h_%0h expected=none", out_pc, out_instr);
            end else begin
                chk("sb_out", {out_pc, out_instr}, exp_q.pop_front());
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        int          req_wait;   // cycles imem_req_ready held low
        int          rsp_wait;   // cycles in WAIT before the response
        int          out_wait;   // cycles out_ready held low in HOLD
        bit          stray;      // drive imem_rsp_valid while in REQ
        logic [31:0] data;       // instruction returned
        logic [31:0] exp_pc;     // expected fetch address / out_pc
    } vec_t;

    vec_t vecs[6];

    // One complete fetch starting with the DUT in REQ.
    task automatic do_fetch(input vec_t v);
        int cyc;
        cyc = 0;
        chk("req_valid", imem_req_valid, 1'b1);
        chk("req_addr", imem_req_addr, v.exp_pc);
        for (int i = 0; i < v.req_wait; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = v.stray;
            imem_rsp_data  = 32'hBAD0_0000 | 32'(i);
            step(); cyc++;
            chk("req_stall_valid", {imem_req_valid, out_valid}, 2'b10);
            chk("req_stall_addr", imem_req_addr, v.exp_pc);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step(); cyc++;
        imem_req_ready = 1'b0;
        chk("wait_outputs", {imem_req_valid, out_valid}, 2'b00);
        for (int i = 0; i < v.rsp_wait; i++) begin
            step(); cyc++;
            chk("wait_stall", {imem_req_valid, out_valid}, 2'b00);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.data;
        exp_q.push_back({v.exp_pc, v.data});
        step(); cyc++;
        imem_rsp_valid = 1'b0;
        chk("hold_valid", {out_valid, imem_req_valid}, 2'b10);
        chk("hold_pc", out_pc, v.exp_pc);
        chk("hold_instr", out_instr, v.data);
        for (int i = 0; i < v.out_wait; i++) begin
            out_ready = 1'b0;
            step(); cyc++;
            chk("hold_stable", {out_valid, imem_req_valid, out_pc, out_instr},
                {1'b1, 1'b0, v.exp_pc, v.data});
        end
        out_ready = 1'b1;
        step(); cyc++;
        out_ready = 1'b0;
        chk("next_req", {imem_req_valid, imem_req_addr}, {1'b1, v.exp_pc + 32'd4});
        chk("fetch_cycles", cyc, 3 + v.req_wait + v.rsp_wait + v.out_wait);
    endtask

    task automatic plain_fetch(input logic [31:0] pc);
        vec_t v;
        v = '{req_wait: 0, rsp_wait: 0, out_wait: 0, stray: 1'b0,
              data: $urandom(), exp_pc: pc};
        do_fetch(v);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{0, 0, 0, 1'b0, 32'h0000_0013, 32'h8000_0000};
        vecs[1] = '{0, 0, 0, 1'b0, 32'h0000_0013, 32'h8000_0004};
        vecs[2] = '{5, 0, 0, 1'b1, $urandom(),    32'h8000_0008};
        vecs[3] = '{0, 0, 4, 1'b0, $urandom(),    32'h8000_000C};
        vecs[4] = '{2, 3, 1, 1'b1, $urandom(),    32'h8000_0010};
        vecs[5] = '{$urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'b0, $urandom(), 32'h8000_0014};

        // Reset values.
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outputs",
            {out_valid, imem_req_valid, imem_req_addr, out_pc, out_instr, dbg_state},
            {1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 2'd0});
        rst = 1'b0;
        step();
        chk("first_req_state", dbg_state, 2'd1);

        // Table-driven fetches, including back-to-back 3-cycle throughput.
        for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

        // Redirect in REQ while memory is stalled: new aligned address next cycle.
        redirect(32'h8000_0042);
        step();
        redirect_valid = 1'b0;
        chk("redir_req_stall", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0040});

        // Redirect in REQ with the request accepted: that response is killed.
        redirect(32'h8000_0300);
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        chk("redir_req_acc_wait", {imem_req_valid, out_valid}, 2'b00);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        chk("redir_req_acc_refetch", {imem_req_valid, imem_req_addr, out_valid},
            {1'b1, 32'h8000_0300, 1'b0});
        plain_fetch(32'h8000_0300);

        // Redirect in WAIT, response two cycles later is discarded.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect(32'h8000_0100);
        step();
        redirect_valid = 1'b0;
        step();
        chk("redir_wait_stay", {imem_req_valid, out_valid}, 2'b00);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("redir_wait_refetch", {imem_req_valid, imem_req_addr, out_valid},
            {1'b1, 32'h8000_0100, 1'b0});
        plain_fetch(32'h8000_0100);

        // Redirect and response in the same WAIT cycle.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect(32'h8000_0400);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("redir_rsp_same", {imem_req_valid, imem_req_addr, out_valid},
            {1'b1, 32'h8000_0400, 1'b0});

        // Redirect in HOLD with a same-cycle IDU handshake: held instr dropped.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        step();
        imem_rsp_valid = 1'b0;
        chk("redir_hold_pre", {out_valid, out_pc}, {1'b1, 32'h8000_0400});
        redirect(32'h8000_0203);
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("redir_hold_refetch", {imem_req_valid, imem_req_addr, out_valid},
            {1'b1, 32'h8000_0200, 1'b0});
        plain_fetch(32'h8000_0200);

        // pc wrap at the top of the address space.
        redirect(32'hFFFF_FFFE);
        step();
        redirect_valid = 1'b0;
        plain_fetch(32'hFFFF_FFFC);
        chk("wrap_addr", imem_req_addr, 32'h0);

        // Reset in WAIT; response and redirect at reset release are ignored.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("reset_mid_wait",
            {out_valid, imem_req_valid, imem_req_addr, out_pc, out_instr, dbg_state},
            {1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 2'd0});
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h4444_4444;
        redirect(32'h8000_0500);
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("reset_release_req", {imem_req_valid, imem_req_addr, out_valid},
            {1'b1, 32'h8000_0000, 1'b0});
        plain_fetch(32'h8000_0000);

        repeat (2) step();
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
